// File: rtl/control_fsm.sv
// Fetch/decode/execute sequencer for a small LC-3-style core: min 3 cycles per instruction.
// Fetch holds imem_req until imem_ack; HALT is terminal until rst.
module control_fsm #(
  parameter logic [5:0] RESET_PC = 6'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [5:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [1:0]  alu_op,
  output logic [1:0]  source_sel,
  output logic [5:0]  ins_immediate,
  output logic [5:0]  pc,
  output logic [2:0]  sr1_addr,
  output logic [2:0]  sr2_addr,
  output logic [2:0]  dr_addr,
  output logic        reg_we,
  input  logic [7:0]  alu_result,
  output logic [2:0]  cc,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t     state;
  logic [3:0] opcode;
  logic [1:0] dec_alu_op;
  logic [1:0] dec_source_sel;
  logic [2:0] next_cc;
  logic       writes_reg;
  logic       take_branch;

  assign imem_addr = pc;

  assign writes_reg = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_NOT) || (opcode == OP_LEA);

  // The BR mask lives in the DR field, so dr_addr doubles as the mask.
  assign take_branch = (opcode == OP_BR) && ((dr_addr & cc) != 3'b000);

  always_comb begin
    dec_alu_op     = 2'b00;
    dec_source_sel = 2'b00;
    case (imem_data[15:12])
      OP_ADD: dec_source_sel = imem_data[5] ? 2'b00 : 2'b10;
      OP_AND: begin
        dec_alu_op     = 2'b01;
        dec_source_sel = imem_data[5] ? 2'b00 : 2'b10;
      end
      OP_NOT: begin
        dec_alu_op     = 2'b10;
        dec_source_sel = imem_data[5] ? 2'b00 : 2'b10;
      end
      OP_LEA: dec_source_sel = 2'b01;
      default: ;
    endcase
  end

  always_comb begin
    next_cc = 3'b001;
    if (alu_result[7])
      next_cc = 3'b100;
    else if (alu_result == 8'd0)
      next_cc = 3'b010;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      cc            <= 3'b010;
      opcode        <= 4'd0;
      alu_op        <= 2'b00;
      source_sel    <= 2'b00;
      ins_immediate <= 6'd0;
      sr1_addr      <= 3'd0;
      sr2_addr      <= 3'd0;
      dr_addr       <= 3'd0;
      reg_we        <= 1'b0;
      imem_req      <= 1'b0;
      halted        <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      case (state)
        FETCH: begin
          // First FETCH cycle after reset only raises the request; acks are ignored until it is up.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            opcode        <= imem_data[15:12];
            dr_addr       <= imem_data[11:9];
            sr1_addr      <= imem_data[8:6];
            sr2_addr      <= imem_data[2:0];
            ins_immediate <= imem_data[5:0];
            alu_op        <= dec_alu_op;
            source_sel    <= dec_source_sel;
            pc            <= pc + 6'd1;
            imem_req      <= 1'b0;
            state         <= DECODE;
          end
        end
        DECODE: begin
          reg_we <= writes_reg;
          state  <= EXECUTE;
        end
        EXECUTE: begin
          if (writes_reg)
            cc <= next_cc;
          if (take_branch)
            pc <= pc + ins_immediate;
          if (opcode == OP_HALT) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
